// File: rtl/adde_2022_shady_tarek_19100178.sv
// Registered 32-bit adder: four 8-bit carry-lookahead slices joined by carry-select,
// with carry/overflow/zero flags captured alongside the sum one clock after the operands.
module adde_2022_shady_tarek_19100178 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] outputt,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero,
  output logic        out_valid
);

  // 8-bit lookahead slice: every internal carry is a flat sum of products of
  // generate/propagate terms and cin, so there is no ripple inside the slice.
  // Returns {carry_out, sum[7:0]}.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic       acc;
    logic       pp;
    logic       grp_g;
    logic       grp_p;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 1; i < 8; i++) begin
      acc = g[i-1];
      pp  = p[i-1];
      for (int j = i - 2; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i] = acc | (pp & cin);
    end
    grp_g = g[7];
    pp    = p[7];
    for (int j = 6; j >= 0; j--) begin
      grp_g = grp_g | (pp & g[j]);
      pp    = pp & p[j];
    end
    grp_p = &p;
    return {grp_g | (grp_p & cin), p ^ c};
  endfunction

  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  always_comb begin
    logic [8:0] s0;
    logic [8:0] r0;
    logic [8:0] r1;
    logic       c;
    sum = '0;
    s0  = cla8(input1[7:0], input2[7:0], 1'b0);
    sum[7:0] = s0[7:0];
    c   = s0[8];
    // upper slices precompute both carry-in cases; the lower slice's carry picks one
    for (int k = 1; k < 4; k++) begin
      r0 = cla8(input1[8*k +: 8], input2[8*k +: 8], 1'b0);
      r1 = cla8(input1[8*k +: 8], input2[8*k +: 8], 1'b1);
      sum[8*k +: 8] = c ? r1[7:0] : r0[7:0];
      c = c ? r1[8] : r0[8];
    end
    cout = c;
    ovf  = (input1[31] == input2[31]) && (sum[31] != input1[31]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outputt   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        outputt   <= sum;
        carry_out <= cout;
        overflow  <= ovf;
        zero      <= ~|sum;
      end
    end
  end

endmodule

// File: tb/tb_adde_2022_shady_tarek_19100178.sv
// Directed and random checks of the registered adder against hand-computed
// values and a 33-bit reference sum.
module tb_adde_2022_shady_tarek_19100178;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] outputt;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  adde_2022_shady_tarek_19100178 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .input1(input1), .input2(input2), .outputt(outputt),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // packed observation {out_valid, zero, overflow, carry_out, outputt}
  function automatic logic [63:0] obs();
    return {28'd0, out_valid, zero, overflow, carry_out, outputt};
  endfunction

  function automatic logic [63:0] pack(input logic v, input logic z, input logic o,
                                       input logic c, input logic [31:0] s);
    return {28'd0, v, z, o, c, s};
  endfunction

  // drive at the falling edge, sample 1 time unit after the capturing rising edge
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v);
    @(negedge clk);
    input1   = a;
    input2   = b;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] ref_sum;
    logic        ref_ovf;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    input1   = '0;
    input2   = '0;
    #12;
    check("reset_state", obs(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    reset_n = 1'b1;

    step(32'd3, 32'd6, 1'b1);
    check("basic_3p6", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd9));
    step(32'd1, 32'd4, 1'b1);
    check("basic_1p4", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd5));

    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("wrap", obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, 32'd0));

    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    check("sovf_pos", obs(), pack(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000));
    step(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("sovf_neg", obs(), pack(1'b1, 1'b1, 1'b1, 1'b1, 32'd0));

    step(32'h00FF_FFFF, 32'h0000_0001, 1'b1);
    check("chain_s2", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'h0100_0000));
    step(32'h0000_FFFF, 32'h0000_0001, 1'b1);
    check("chain_s1", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_0000));
    step(32'h0000_00FF, 32'h0000_0001, 1'b1);
    check("chain_s0", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100));
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("neg1_neg1", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE));

    step(32'd10, 32'd20, 1'b1);
    check("hold_load", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd30));
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("hold_1", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 32'd30));
    step(32'h1234_5678, 32'h1111_1111, 1'b0);
    check("hold_2", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 32'd30));

    step(32'd5, 32'd7, 1'b1);
    check("pre_reset", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd12));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    reset_n = 1'b1;
    step(32'd100, 32'd200, 1'b1);
    check("post_reset", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd300));

    for (int i = 0; i < 1000; i++) begin
      a = $urandom();
      b = $urandom();
      if (i % 50 == 0) b = 32'd0 - a;
      ref_sum = {1'b0, a} + {1'b0, b};
      ref_ovf = (a[31] == b[31]) && (ref_sum[31] != a[31]);
      step(a, b, 1'b1);
      check("random", obs(),
            pack(1'b1, ref_sum[31:0] == 32'd0, ref_ovf, ref_sum[32], ref_sum[31:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
